// File: rtl/uart_wb_fifo.sv
// Wishbone classic 8N1 UART slave with RX/TX FIFOs, sticky error flags and a maskable level irq.
// Define UART_WB_FIFO_LOOPBACK_EN to build the CTRL[2] internal TX->RX loopback.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronised falling edge
// RX_START | counting to mid start bit, then re-checking the line
// RX_DATA  | sampling 8 data bits LSB first, one per DIV cycles
// RX_STOP  | sampling the stop bit: push byte or flag FE
// TX_IDLE  | waiting for TX FIFO data
// TX_START | driving the start bit for DIV cycles
// TX_DATA  | shifting out 8 data bits LSB first
// TX_STOP  | driving the stop bit for DIV cycles
module uart_wb_fifo #(
    parameter logic [31:0] ADR       = 32'h0000_00F0,
    parameter int          DEPTH     = 16,
    parameter int          DIV_RESET = 2500
) (
    input  logic        clk_48_i,
    input  logic        rst_n_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic        hit;
    logic [1:0]  offset;
    logic        rd_data, wr_data, wr_status, wr_div, wr_ctrl;
    logic [31:0] rd_value;
    logic [15:0] div;
    logic        rx_ie, tx_ie, lb_bit;
    logic        rx_ovr, fe, tx_ovr;
    logic        unused_inputs;

    assign offset    = adr_i[3:2];
    assign hit       = stb_i & cyc_i & (adr_i[31:4] == ADR[31:4]) & ~ack_o;
    assign rd_data   = hit & ~we_i & (offset == 2'd0);
    assign wr_data   = hit &  we_i & (offset == 2'd0);
    assign wr_status = hit &  we_i & (offset == 2'd1);
    assign wr_div    = hit &  we_i & (offset == 2'd2);
    assign wr_ctrl   = hit &  we_i & (offset == 2'd3);
    assign unused_inputs = &{1'b0, sel_i, adr_i[1:0], dat_i[31:16]};

    // FIFO storage and pointers; pointers carry one extra wrap bit
    logic [7:0]  rx_mem [DEPTH];
    logic [7:0]  tx_mem [DEPTH];
    logic [AW:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        rx_push, rx_pop, rx_push_ok, rx_ovr_set, fe_set;
    logic        tx_pop, tx_push_ok, tx_ovr_set;

    assign rx_empty   = (rx_wptr == rx_rptr);
    assign rx_full    = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign tx_empty   = (tx_wptr == tx_rptr);
    assign tx_full    = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_push_ok = rx_push & (~rx_full | rx_pop);
    assign tx_push_ok = wr_data & (~tx_full | tx_pop);
    assign tx_ovr_set = wr_data & tx_full & ~tx_pop;

    // Serial line routing
    logic tx_line, rx_src;
`ifdef UART_WB_FIFO_LOOPBACK_EN
    logic lb_en;
    assign lb_bit = lb_en;
    assign rx_src = lb_en ? tx_line : rx_i;
    assign tx_o   = lb_en ? 1'b1 : tx_line;
`else
    assign lb_bit = 1'b0;
    assign rx_src = rx_i;
    assign tx_o   = tx_line;
`endif

    // RX FSM signals
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_prev, rx_fall;

    assign rx_fall = rx_prev & ~rx_s2;

    // TX FSM signals
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n, tx_busy;

    assign tx_busy = (tx_state != TX_IDLE);

    always_comb begin
        rd_value = '0;
        case (offset)
            2'd0: if (!rx_empty) rd_value = {23'b0, 1'b1, rx_mem[rx_rptr[AW-1:0]]};
            2'd1: rd_value = {24'b0, tx_busy, tx_ovr, fe, rx_ovr,
                              tx_full, tx_empty, rx_full, ~rx_empty};
            2'd2: rd_value = {16'b0, div};
            default: rd_value = {29'b0, lb_bit, tx_ie, rx_ie};
        endcase
    end

    always_ff @(posedge clk_48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            div    <= 16'(DIV_RESET);
            rx_ie  <= 1'b0;
            tx_ie  <= 1'b0;
            rx_ovr <= 1'b0;
            fe     <= 1'b0;
            tx_ovr <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            ack_o <= hit;
            dat_o <= (hit && !we_i) ? rd_value : '0;
            if (wr_div) div <= (dat_i[15:0] < 16'd4) ? 16'd4 : dat_i[15:0];
            if (wr_ctrl) begin
                rx_ie <= dat_i[0];
                tx_ie <= dat_i[1];
            end
            // a flag raised in the same cycle as its clear stays set
            rx_ovr <= (rx_ovr & ~(wr_status & dat_i[4])) | rx_ovr_set;
            fe     <= (fe     & ~(wr_status & dat_i[5])) | fe_set;
            tx_ovr <= (tx_ovr & ~(wr_status & dat_i[6])) | tx_ovr_set;
            irq_o  <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);
        end
    end

`ifdef UART_WB_FIFO_LOOPBACK_EN
    always_ff @(posedge clk_48_i or negedge rst_n_i) begin
        if (!rst_n_i)     lb_en <= 1'b0;
        else if (wr_ctrl) lb_en <= dat_i[2];
    end
`endif

    always_ff @(posedge clk_48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (rx_push_ok) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)     rx_rptr <= rx_rptr + 1'b1;
            if (tx_push_ok) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)     tx_rptr <= tx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_48_i) begin
        if (rx_push_ok) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
        if (tx_push_ok) tx_mem[tx_wptr[AW-1:0]] <= dat_i[7:0];
    end

    always_ff @(posedge clk_48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'(DIV_RESET);
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rx_src;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Down-counter timing: a state acts when rx_cnt reaches zero
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ovr_set = 1'b0;
        fe_set     = 1'b0;
        if (rx_state != RX_IDLE && rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        case (rx_state)
            RX_IDLE: if (rx_fall) begin
                rx_state_n = RX_START;
                rx_div_n   = div;
                rx_cnt_n   = {1'b0, div[15:1]};
            end
            RX_START: if (rx_cnt == 16'd0) begin
                if (rx_s2) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    rx_cnt_n   = rx_div - 16'd1;
                    rx_bit_n   = 3'd0;
                end
            end
            RX_DATA: if (rx_cnt == 16'd0) begin
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_cnt_n   = rx_div - 16'd1;
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == 16'd0) begin
                rx_state_n = RX_IDLE;
                if (rx_s2) begin
                    rx_push    = 1'b1;
                    rx_ovr_set = rx_full & ~rx_pop;
                end else begin
                    fe_set = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= 16'(DIV_RESET);
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        if (tx_state != TX_IDLE && tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_n = tx_mem[tx_rptr[AW-1:0]];
                tx_line_n  = 1'b0;
                tx_div_n   = div;
                tx_cnt_n   = div - 16'd1;
                tx_state_n = TX_START;
            end
            TX_START: if (tx_cnt == 16'd0) begin
                tx_state_n = TX_DATA;
                tx_line_n  = tx_shift[0];
                tx_cnt_n   = tx_div - 16'd1;
                tx_bit_n   = 3'd0;
            end
            TX_DATA: if (tx_cnt == 16'd0) begin
                tx_cnt_n = tx_div - 16'd1;
                if (tx_bit == 3'd7) begin
                    tx_state_n = TX_STOP;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_bit_n   = tx_bit + 3'd1;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_line_n  = tx_shift[1];
                end
            end
            TX_STOP: if (tx_cnt == 16'd0) tx_state_n = TX_IDLE;
            default: tx_state_n = TX_IDLE;
        endcase
    end

endmodule

// File: doc/uart_wb_fifo.md
Name: uart_wb_fifo

Overview:
- Next-generation Wishbone classic UART slave, 8N1, with runtime-programmable baud divisor, parametrised-depth RX and TX FIFOs, sticky error flags and maskable interrupt.
- Sits on the SoC Wishbone bus beside the CPU. Firmware echo/console code polls STATUS or services irq_o instead of reading one byte per interrupt.

Parameters:
- ADR, 32'h0000_00F0: bus base address; the block decodes adr_i[31:4] == ADR[31:4].
- DEPTH, 16: entries per FIFO; power of 2, range 2..256.
- DIV_RESET, 2500: reset baud divisor in clk cycles per bit (48 MHz / 19200).

Ports:
- clk_48_i  in  1  system clock, 48 MHz.
- rst_n_i  in  1  asynchronous active-low reset.
- adr_i  in  32  Wishbone address.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- we_i  in  1  1 = write.
- sel_i  in  4  byte selects; ignored, full-word access only.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- tx_o  out  1  serial TX, idle high.
- rx_i  in  1  serial RX, asynchronous to clk.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (rst_n_i low, asynchronous): ack_o=0, dat_o=0, tx_o=1, irq_o=0, FIFOs empty, DIV=DIV_RESET, CTRL=0, sticky flags=0, RX/TX FSMs in IDLE.
- Bus access:
  - A hit is stb_i & cyc_i & address match & !ack_o.
  - ack_o is registered: high exactly 1 cycle, the cycle after a hit. dat_o is valid in the same cycle as ack_o.
  - Because of the !ack_o term, back-to-back accesses take 2 cycles each.
  - Non-matching addresses get no ack.
- Register map (offset = adr_i[3:2]):
  - 0 DATA
    - Read: pops RX FIFO, returns {23'b0, valid, byte}. valid=0 and byte=0 when the FIFO is empty; no pop then.
    - Write: pushes dat_i[7:0] to TX FIFO. If TX is full, the byte is dropped and TX_OVR is set.
  - 1 STATUS
    - Read: [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] RX_OVR, [5] FE, [6] TX_OVR, [7] tx_busy (TX FSM not IDLE).
    - Write: 1-to-clear on bits [6:4]; other bits ignored.
  - 2 DIV, 16 bits: cycles per bit. A write below 4 stores 4. Takes effect at the next start bit of each FSM.
  - 3 CTRL: [0] rx_ie, [1] tx_ie, [2] loopback (see optional feature). Other bits read 0.
- irq_o is registered: (rx_ie & rx_nonempty) | (tx_ie & tx_empty & !tx_busy).
- RX path:
  - rx_i passes through a 2-flop synchroniser (reset value 1).
  - States IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised falling edge; counter loaded with DIV/2.
  - START: when the counter expires, sample the line. If high, it is a false start: go to IDLE, nothing pushed. If low, go to DATA.
  - DATA: 8 samples, one every DIV cycles, LSB first.
  - STOP: sample after DIV cycles.
    - Line high: push the byte. If RX is full, drop the byte and set RX_OVR.
    - Line low: discard the byte and set FE.
    - Either way go to IDLE.
- TX path:
  - States IDLE, START, DATA, STOP; each state holds for DIV cycles.
  - IDLE: when the TX FIFO is non-empty, pop it and drive tx_o=0.
  - DATA: shift out LSB first. STOP: drive tx_o=1.
  - After STOP, re-enter IDLE; the next byte starts 1 cycle later.
- FIFOs:
  - Circular buffers with read/write pointers one bit wider than log2(DEPTH) for full/empty detection; pointers wrap at DEPTH.
  - Simultaneous push and pop on the same FIFO:
    - Both succeed when the FIFO is non-empty.
    - When it is empty, the pop sees empty and the push lands.
    - When it is full, the pop frees a slot, so the push succeeds and no overflow is flagged.
- Reset mid-frame: tx_o returns to 1 immediately; a partial RX byte is lost.

Optional Feature:
- Macro: UART_WB_FIFO_LOOPBACK_EN.
- Defined: CTRL[2]=1 feeds the RX synchroniser from the internal TX line instead of rx_i, and forces tx_o high.
- Undefined: CTRL[2] is not implemented and reads 0, rx_i always drives RX, no mux logic.

Test Plan:
- Reset, then read STATUS -> 0x0000_0004 (tx_empty). Read DIV -> 2500. tx_o=1, irq_o=0.
- Write DIV=16, write DATA=0x55 -> tx_o low 16 cycles (start), then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16 cycles. tx_busy=1 during the frame.
- DIV=16, drive an rx_i frame for 0xA3 -> STATUS[0]=1. Set rx_ie -> irq_o=1. Read DATA -> 0x0000_01A3, then irq_o drops. A second read returns 0x0000_0000.
- DEPTH=16: receive 17 frames 0x00..0x10 without reading -> rx_full=1, RX_OVR=1. The 16 reads return 0x00..0x0F in order. Write STATUS=0x10 -> RX_OVR clears.
- rx_i frame with stop bit low -> FE=1, FIFO still empty. An 8-cycle low glitch with DIV=32 -> no push, no FE.
- With UART_WB_FIFO_LOOPBACK_EN defined: CTRL=4, write DATA=0x3C -> DATA read after one frame returns 0x13C, tx_o held 1 throughout.
